// File: rtl/exc_commit.sv
// Exception commit unit: turns the MEM-stage exception verdict into CP0 strobes, a flush and a fetch redirect.
// Optional macro EXC_IV_EN: interrupts with Cause.IV=1 use vector offset 0x200.
module exc_commit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        commit_valid,
  input  logic        exc_flag,
  input  logic [4:0]  exc_type,
  input  logic [31:0] exc_baddr,
  input  logic        exc_save,
  input  logic [31:0] pc,
  input  logic        in_delay,
  input  logic        is_store,
  input  logic [31:0] cp0_Status,
  input  logic [31:0] cp0_Cause,
  input  logic [31:0] cp0_EPC,
  output logic        flush,
  output logic        epc_we,
  output logic [31:0] epc_wdata,
  output logic        cause_we,
  output logic        cause_bd,
  output logic [4:0]  cause_excode,
  output logic        exl_we,
  output logic        exl_wdata,
  output logic        erl_clr,
  output logic        bva_we,
  output logic [31:0] bva_wdata,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  input  logic        redir_ready,
  output logic        busy
);

  // exc_type encoding shared with the exception priority encoder
  localparam logic [4:0] EXCT_INTR = 5'd1;
  localparam logic [4:0] EXCT_TLBM = 5'd2;
  localparam logic [4:0] EXCT_TLBR = 5'd3;
  localparam logic [4:0] EXCT_TLBI = 5'd4;
  localparam logic [4:0] EXCT_ADEL = 5'd5;
  localparam logic [4:0] EXCT_ADES = 5'd6;
  localparam logic [4:0] EXCT_SYSC = 5'd7;
  localparam logic [4:0] EXCT_BP   = 5'd8;
  localparam logic [4:0] EXCT_RI   = 5'd9;
  localparam logic [4:0] EXCT_CPU  = 5'd10;
  localparam logic [4:0] EXCT_OV   = 5'd11;
  localparam logic [4:0] EXCT_TRAP = 5'd12;
  localparam logic [4:0] EXCT_ERET = 5'd13;

  typedef enum logic [0:0] {IDLE = 1'b0, REDIR = 1'b1} state_t;
  state_t r_state;

  logic        w_commit;
  logic        w_eret;
  logic        w_exl;
  logic        w_erl;
  logic        w_bev;
  logic [4:0]  w_excode;
  logic [31:0] w_base;
  logic [31:0] w_off;
  logic [31:0] w_vector;
  logic [31:0] w_epc;
  logic        w_unused;

  assign w_unused = ^{cp0_Status, cp0_Cause};

  // Decode the verdict into ExcCode, vector address and EPC value
  always_comb begin
    w_commit = commit_valid & exc_flag;
    w_eret   = (exc_type == EXCT_ERET);
    w_exl    = cp0_Status[1];
    w_erl    = cp0_Status[2];
    w_bev    = cp0_Status[22];
    w_excode = 5'd0;
    case (exc_type)
      EXCT_INTR: w_excode = 5'd0;
      EXCT_TLBM: w_excode = 5'd1;
      EXCT_TLBR,
      EXCT_TLBI: w_excode = is_store ? 5'd3 : 5'd2;
      EXCT_ADEL: w_excode = 5'd4;
      EXCT_ADES: w_excode = 5'd5;
      EXCT_SYSC: w_excode = 5'd8;
      EXCT_BP:   w_excode = 5'd9;
      EXCT_RI:   w_excode = 5'd10;
      EXCT_CPU:  w_excode = 5'd11;
      EXCT_OV:   w_excode = 5'd12;
      EXCT_TRAP: w_excode = 5'd13;
      default:   w_excode = 5'd0;
    endcase
    w_base = w_bev ? 32'hBFC0_0200 : 32'h8000_0000;
    // A TLB refill taken at EXL=1 is a nested miss and goes to the general vector
    if (exc_type == EXCT_TLBR && !w_exl) begin
      w_off = 32'h0000_0000;
`ifdef EXC_IV_EN
    end else if (exc_type == EXCT_INTR && cp0_Cause[23]) begin
      w_off = 32'h0000_0200;
`endif
    end else begin
      w_off = 32'h0000_0180;
    end
    w_vector = w_base + w_off;
    w_epc    = in_delay ? (pc - 32'd4) : pc;
  end

  // Control FSM with registered strobes and redirect handshake
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      flush        <= 1'b0;
      epc_we       <= 1'b0;
      epc_wdata    <= 32'd0;
      cause_we     <= 1'b0;
      cause_bd     <= 1'b0;
      cause_excode <= 5'd0;
      exl_we       <= 1'b0;
      exl_wdata    <= 1'b0;
      erl_clr      <= 1'b0;
      bva_we       <= 1'b0;
      bva_wdata    <= 32'd0;
      redir_valid  <= 1'b0;
      redir_pc     <= 32'd0;
      busy         <= 1'b0;
    end else begin
      flush    <= 1'b0;
      epc_we   <= 1'b0;
      cause_we <= 1'b0;
      exl_we   <= 1'b0;
      erl_clr  <= 1'b0;
      bva_we   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_commit) begin
            r_state     <= REDIR;
            flush       <= 1'b1;
            redir_valid <= 1'b1;
            busy        <= 1'b1;
            if (w_eret) begin
              redir_pc     <= cp0_EPC;
              cause_bd     <= 1'b0;
              cause_excode <= 5'd0;
              erl_clr      <= w_erl;
              exl_we       <= ~w_erl;
              exl_wdata    <= 1'b0;
            end else begin
              redir_pc     <= w_vector;
              epc_we       <= ~w_exl;
              epc_wdata    <= w_epc;
              cause_we     <= 1'b1;
              cause_bd     <= in_delay & ~w_exl;
              cause_excode <= w_excode;
              exl_we       <= 1'b1;
              exl_wdata    <= 1'b1;
              bva_we       <= exc_save;
              bva_wdata    <= exc_baddr;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        REDIR: begin
          if (redir_ready) begin
            r_state     <= IDLE;
            redir_valid <= 1'b0;
            busy        <= 1'b0;
          end else begin
            r_state <= REDIR;
          end
        end
        default: begin
          r_state     <= IDLE;
          redir_valid <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exc_commit.sv
// Table-driven bench for exc_commit plus hand-written stall, ignore-during-REDIR and async-reset sequences.
module tb_exc_commit;

  localparam logic [4:0] T_INTR = 5'd1;
  localparam logic [4:0] T_TLBM = 5'd2;
  localparam logic [4:0] T_TLBR = 5'd3;
  localparam logic [4:0] T_TLBI = 5'd4;
  localparam logic [4:0] T_ADEL = 5'd5;
  localparam logic [4:0] T_ADES = 5'd6;
  localparam logic [4:0] T_SYSC = 5'd7;
  localparam logic [4:0] T_BP   = 5'd8;
  localparam logic [4:0] T_RI   = 5'd9;
  localparam logic [4:0] T_CPU  = 5'd10;
  localparam logic [4:0] T_OV   = 5'd11;
  localparam logic [4:0] T_TRAP = 5'd12;
  localparam logic [4:0] T_ERET = 5'd13;

`ifdef EXC_IV_EN
  localparam logic [31:0] IV_NOBEV = 32'h8000_0200;
  localparam logic [31:0] IV_BEV   = 32'hBFC0_0400;
`else
  localparam logic [31:0] IV_NOBEV = 32'h8000_0180;
  localparam logic [31:0] IV_BEV   = 32'hBFC0_0380;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        commit_valid = 1'b0, exc_flag = 1'b0, exc_save = 1'b0;
  logic [4:0]  exc_type = 5'd0;
  logic [31:0] exc_baddr = 32'd0, pc = 32'd0;
  logic        in_delay = 1'b0, is_store = 1'b0, redir_ready = 1'b1;
  logic [31:0] cp0_Status = 32'd0, cp0_Cause = 32'd0, cp0_EPC = 32'd0;
  logic        flush, epc_we, cause_we, cause_bd, exl_we, exl_wdata, erl_clr, bva_we, redir_valid, busy;
  logic [31:0] epc_wdata, bva_wdata, redir_pc;
  logic [4:0]  cause_excode;

  int n_checks = 0;
  int n_errors = 0;

  exc_commit dut (
    .clk(clk), .resetn(resetn), .commit_valid(commit_valid), .exc_flag(exc_flag),
    .exc_type(exc_type), .exc_baddr(exc_baddr), .exc_save(exc_save), .pc(pc),
    .in_delay(in_delay), .is_store(is_store), .cp0_Status(cp0_Status),
    .cp0_Cause(cp0_Cause), .cp0_EPC(cp0_EPC), .flush(flush), .epc_we(epc_we),
    .epc_wdata(epc_wdata), .cause_we(cause_we), .cause_bd(cause_bd),
    .cause_excode(cause_excode), .exl_we(exl_we), .exl_wdata(exl_wdata),
    .erl_clr(erl_clr), .bva_we(bva_we), .bva_wdata(bva_wdata),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ready(redir_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  typ;
    logic [31:0] pc;
    logic        dly;
    logic        st;
    logic        save;
    logic [31:0] baddr;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        e_epc_we;
    logic [31:0] e_epc;
    logic        e_cause_we;
    logic        e_bd;
    logic [4:0]  e_code;
    logic        e_exl_we;
    logic        e_exl_wd;
    logic        e_erl;
    logic        e_bva_we;
    logic [31:0] e_bva;
    logic [31:0] e_redir;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_commit(input vec_t v);
    exc_type = v.typ; pc = v.pc; in_delay = v.dly; is_store = v.st; exc_save = v.save;
    exc_baddr = v.baddr; cp0_Status = v.status; cp0_Cause = v.cause; cp0_EPC = v.epc;
    commit_valid = 1'b1; exc_flag = 1'b1;
  endtask

  task automatic check_idle_quiet(input string tag);
    chk({tag, "_ctl"}, {22'd0, flush, epc_we, cause_we, exl_we, erl_clr, bva_we, redir_valid, busy, 2'd0},
        32'd0);
  endtask

  initial begin
    //           typ     pc             dly   st    save  baddr          status         cause          epc
    //           e_epc_we e_epc         cwe   bd    code   exl_we wd   erl   bva_we bva           redir
    vecs[0]  = '{T_OV,   32'h8000_1000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0, 32'h0,
                 1'b1, 32'h8000_0FFC, 1'b1, 1'b1, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h8000_0180};
    vecs[1]  = '{T_TLBR, 32'h0040_0000, 1'b0, 1'b1, 1'b1, 32'h0040_0010, 32'h0000_0000, 32'h0, 32'h0,
                 1'b1, 32'h0040_0000, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0040_0010, 32'h8000_0000};
    vecs[2]  = '{T_TLBR, 32'h0040_0000, 1'b0, 1'b1, 1'b1, 32'h0040_0010, 32'h0000_0002, 32'h0, 32'h0,
                 1'b0, 32'h0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0040_0010, 32'h8000_0180};
    vecs[3]  = '{T_ERET, 32'h8000_5000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0000, 32'h0, 32'h8000_2000,
                 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h8000_2000};
    vecs[4]  = '{T_ERET, 32'h8000_5000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0004, 32'h0, 32'h8000_2000,
                 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h8000_2000};
    vecs[5]  = '{T_SYSC, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0000, 32'h0, 32'h0,
                 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h8000_0180};
    vecs[6]  = '{T_ADEL, 32'h8000_3000, 1'b0, 1'b0, 1'b1, 32'h1234_5679, 32'h0040_0000, 32'h0, 32'h0,
                 1'b1, 32'h8000_3000, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1234_5679, 32'hBFC0_0380};
    vecs[7]  = '{T_TLBI, 32'h8000_4000, 1'b0, 1'b0, 1'b1, 32'h0000_1000, 32'h0000_0000, 32'h0, 32'h0,
                 1'b1, 32'h8000_4000, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_1000, 32'h8000_0180};
    vecs[8]  = '{T_TLBM, 32'h8000_4004, 1'b0, 1'b1, 1'b1, 32'h0000_2000, 32'h0000_0000, 32'h0, 32'h0,
                 1'b1, 32'h8000_4004, 1'b1, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_2000, 32'h8000_0180};
    vecs[9]  = '{T_TLBR, 32'h8000_4008, 1'b0, 1'b0, 1'b1, 32'h0000_3000, 32'h0040_0000, 32'h0, 32'h0,
                 1'b1, 32'h8000_4008, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_3000, 32'hBFC0_0200};
    vecs[10] = '{T_OV,   32'h8000_1000, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0002, 32'h0, 32'h0,
                 1'b0, 32'h0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h8000_0180};
    vecs[11] = '{T_INTR, 32'h8000_6000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0000, 32'h0080_0000, 32'h0,
                 1'b1, 32'h8000_6000, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, IV_NOBEV};
    vecs[12] = '{T_INTR, 32'h8000_6000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0040_0000, 32'h0080_0000, 32'h0,
                 1'b1, 32'h8000_6000, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, IV_BEV};
    vecs[13] = '{T_INTR, 32'h8000_6000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0000, 32'h0000_0000, 32'h0,
                 1'b1, 32'h8000_6000, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h8000_0180};
    vecs[14] = '{T_TRAP, 32'h8000_7000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0000, 32'h0, 32'h0,
                 1'b1, 32'h8000_7000, 1'b1, 1'b0, 5'd13, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h8000_0180};
    vecs[15] = '{T_ADES, 32'h8000_7004, 1'b1, 1'b1, 1'b1, 32'h0000_0003, 32'h0000_0000, 32'h0, 32'h0,
                 1'b1, 32'h8000_7000, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0003, 32'h8000_0180};
    vecs[16] = '{T_RI,   32'h8000_7008, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0000, 32'h0, 32'h0,
                 1'b1, 32'h8000_7008, 1'b1, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h8000_0180};
    vecs[17] = '{T_BP,   32'h8000_700C, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0000, 32'h0, 32'h0,
                 1'b1, 32'h8000_700C, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h8000_0180};
    vecs[18] = '{T_CPU,  32'h8000_7010, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0040_0000, 32'h0, 32'h0,
                 1'b1, 32'h8000_7010, 1'b1, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'hBFC0_0380};

    // Reset state, then idle cycles with only one of the two commit qualifiers
    repeat (3) @(negedge clk);
    chk("reset_ctl", {17'd0, flush, epc_we, cause_we, cause_bd, exl_we, exl_wdata, erl_clr, bva_we,
                      redir_valid, busy, cause_excode}, 32'd0);
    chk("reset_epc", epc_wdata, 32'd0);
    chk("reset_bva", bva_wdata, 32'd0);
    chk("reset_redir", redir_pc, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    exc_type = T_OV; commit_valid = 1'b1; exc_flag = 1'b0;
    @(negedge clk);
    check_idle_quiet("noflag");
    commit_valid = 1'b0; exc_flag = 1'b1;
    @(negedge clk);
    check_idle_quiet("novalid");
    exc_flag = 1'b0;
    @(negedge clk);

    // Table: one commit per vector, redirect accepted immediately
    for (int i = 0; i < 19; i++) begin
      drive_commit(vecs[i]);
      @(negedge clk);
      commit_valid = 1'b0; exc_flag = 1'b0;
      chk($sformatf("v%0d_flush", i), {31'd0, flush}, 32'd1);
      chk($sformatf("v%0d_valid", i), {30'd0, redir_valid, busy}, 32'd3);
      chk($sformatf("v%0d_epc_we", i), {31'd0, epc_we}, {31'd0, vecs[i].e_epc_we});
      if (vecs[i].e_epc_we) chk($sformatf("v%0d_epc", i), epc_wdata, vecs[i].e_epc);
      chk($sformatf("v%0d_cause", i), {25'd0, cause_we, cause_bd, cause_excode},
          {25'd0, vecs[i].e_cause_we, vecs[i].e_bd, vecs[i].e_code});
      chk($sformatf("v%0d_exl", i), {30'd0, exl_we, erl_clr}, {30'd0, vecs[i].e_exl_we, vecs[i].e_erl});
      if (vecs[i].e_exl_we) chk($sformatf("v%0d_exl_wd", i), {31'd0, exl_wdata}, {31'd0, vecs[i].e_exl_wd});
      chk($sformatf("v%0d_bva_we", i), {31'd0, bva_we}, {31'd0, vecs[i].e_bva_we});
      if (vecs[i].e_bva_we) chk($sformatf("v%0d_bva", i), bva_wdata, vecs[i].e_bva);
      chk($sformatf("v%0d_redir", i), redir_pc, vecs[i].e_redir);
      @(negedge clk);
      check_idle_quiet($sformatf("v%0d_after", i));
    end

    // Stall: ready low for 3 cycles, a second commit is presented during REDIR
    redir_ready = 1'b0;
    drive_commit(vecs[0]);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        commit_valid = 1'b0; exc_flag = 1'b0;
      end
      chk($sformatf("stall%0d_flush", k), {31'd0, flush}, (k == 0) ? 32'd1 : 32'd0);
      chk($sformatf("stall%0d_strobes", k), {27'd0, epc_we, cause_we, exl_we, erl_clr, bva_we},
          (k == 0) ? 32'h1C : 32'h0);
      chk($sformatf("stall%0d_valid", k), {30'd0, redir_valid, busy}, 32'd3);
      chk($sformatf("stall%0d_pc", k), redir_pc, 32'h8000_0180);
      if (k == 1) begin
        drive_commit(vecs[16]);
      end
      if (k == 3) begin
        commit_valid = 1'b0; exc_flag = 1'b0; redir_ready = 1'b1;
      end
    end
    @(negedge clk);
    check_idle_quiet("stall_done");

    // Asynchronous reset while a redirect is outstanding
    redir_ready = 1'b0;
    drive_commit(vecs[1]);
    @(negedge clk);
    commit_valid = 1'b0; exc_flag = 1'b0;
    chk("rst_pre_valid", {31'd0, redir_valid}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("rst_async", {30'd0, redir_valid, busy}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    redir_ready = 1'b1;
    @(negedge clk);
    check_idle_quiet("rst_after");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/exc_commit.md
# exc_commit

Exception commit unit: consumes the prioritised exception verdict produced at the MEM stage (exc_flag, exc_type, exc_baddr, exc_save) and turns it into architectural side effects. It issues one-cycle CP0 update strobes (EPC, Cause.BD/ExcCode, Status.EXL, BadVAddr), flushes the pipeline, and drives a valid/ready redirect to the fetch stage with the exception vector or the ERET target. It sits between the exception priority encoder and CP0/IF.

## Interface
- No parameters; widths come from `AddrBus`, `DataBus` and `ExcType` in Defines.v.
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- commit_valid  in  1  MEM-stage instruction is valid this cycle
- exc_flag  in  1  exception or ERET present
- exc_type  in  `ExcType`  prioritised type (ExcT_*)
- exc_baddr  in  `AddrBus`  faulting address
- exc_save  in  1  BadVAddr must be written
- pc  in  `AddrBus`  PC of the committing instruction
- in_delay  in  1  instruction is in a branch delay slot
- is_store  in  1  faulting access is a store
- cp0_Status  in  `DataBus`  current Status (EXL, ERL, BEV used)
- cp0_Cause  in  `DataBus`  current Cause (IV used only with EXC_IV_EN)
- cp0_EPC  in  `AddrBus`  current EPC
- flush  out  1  kill IF..MEM
- epc_we / epc_wdata  out  1 / `AddrBus`  EPC update
- cause_we / cause_bd / cause_excode  out  1 / 1 / 5  Cause update
- exl_we / exl_wdata  out  1 / 1  Status.EXL update
- erl_clr  out  1  clear Status.ERL
- bva_we / bva_wdata  out  1 / `AddrBus`  BadVAddr update
- redir_valid / redir_pc  out  1 / `AddrBus`  fetch redirect
- redir_ready  in  1  fetch accepts redirect
- busy  out  1  redirect outstanding; MEM must stall

## Operation
- FSM states: IDLE, REDIR.
- IDLE: a commit occurs when commit_valid && exc_flag. Inputs are latched; next cycle enter REDIR.
- ExcCode mapping: Intr 0; TLBM 1; TLBR/TLBI → 2 (load) or 3 (is_store); AdEL 4; AdES 5; SysC 8; Bp 9; RI 10; CpU 11; Ov 12; Trap 13.
- Non-ERET exception, with EXL=0 beforehand: epc_we with wdata = in_delay ? pc−4 : pc; cause_bd = in_delay. With EXL=1: epc_we=0, cause_bd not updated (cause_bd driven 0, cause_we still 1 for ExcCode).
- Always for non-ERET: cause_we=1, exl_we=1, exl_wdata=1; bva_we = exc_save, bva_wdata = exc_baddr.
- Vector: base = BEV ? 0xBFC00200 : 0x80000000; offset = 0x000 if type TLBR and EXL=0, else 0x180.
- ERET: no EPC/Cause/BadVAddr writes. If ERL=1: erl_clr=1; else exl_we=1, exl_wdata=0. redir_pc = cp0_EPC.
- REDIR: redir_valid=1, redir_pc stable, busy=1; leave to IDLE on the cycle redir_ready=1.
- Arithmetic: address arithmetic is modulo 2^32; pc−4 wraps (pc=0 gives 0xFFFFFFFC).

## Timing
- Reset: all outputs 0, state IDLE, latched registers 0.
- Cycle N: commit sampled. Cycle N+1: flush, all *_we, erl_clr pulse exactly one cycle; redir_valid rises and busy=1.
- redir_valid and redir_pc are held until the handshake; minimum REDIR occupancy 1 cycle (redir_ready already high at N+1 → IDLE at N+2).
- In REDIR, commit inputs are ignored; no second set of strobes.
- Commit in IDLE with exc_flag=0 or commit_valid=0: no outputs.
- resetn asserted mid-REDIR: immediate return to IDLE, redir_valid drops asynchronously.
- All outputs are registered; no combinational input→output paths.

## Configuration
- EXC_IV_EN defined: ExcT_Intr with cp0_Cause.IV=1 and BEV=0 uses offset 0x200 (0x80000200); BEV=1 gives 0xBFC00400. Undefined: cp0_Cause is unused and interrupts use offset 0x180.

## Test plan
- Reset: resetn=0 → all outputs 0; after release, idle with exc_flag=0 → no strobes.
- Ov at pc=0x80001000, in_delay=1, EXL=0, BEV=0 → N+1: epc_wdata=0x80000FFC, cause_bd=1, excode=12, redir_pc=0x80000180, flush pulse 1 cycle.
- TLBR store, exc_save=1, baddr=0x00400010, EXL=0 → excode=3, bva_wdata=0x00400010, redir_pc=0x80000000; repeat with EXL=1 → epc_we=0, redir_pc=0x80000180.
- ERET with EPC=0x80002000, ERL=0 → exl_wdata=0, redir_pc=0x80002000; with ERL=1 → erl_clr=1, no exl_we.
- redir_ready low 3 cycles → redir_valid/busy held 4 cycles, redir_pc constant; new commit during REDIR produces no strobes; resetn pulse in REDIR clears redir_valid at once.
- EXC_IV_EN: Intr, IV=1, BEV=0 → 0x80000200; IV=0 → 0x80000180; macro undefined with IV=1 → 0x80000180.
